// File: rtl/maze_path_player_pkg.sv
// Shared constants and types for the maze path player: move codes, path
// endpoints and the controller state encoding.
package maze_path_player_pkg;

  localparam logic [1:0] MV_RIGHT = 2'b00;
  localparam logic [1:0] MV_DOWN  = 2'b01;
  localparam logic [1:0] MV_LEFT  = 2'b10;
  localparam logic [1:0] MV_UP    = 2'b11;

  localparam logic [7:0] LOC_DEST  = 8'hFF;
  localparam logic [7:0] LOC_START = 8'h00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_LOAD,
    S_PLAY,
    S_ERR
  } state_t;

  typedef struct packed {
    logic       ok;
    logic [1:0] mv;
  } step_t;

endpackage

// File: rtl/path_lifo_ram.sv
// Path location store: synchronous write, asynchronous read, no reset on
// contents.
module path_lifo_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/maze_path_player.sv
// Captures the solver's unwound path (destination first) and replays it
// start-to-destination as a valid/ready stream of move codes.
module maze_path_player
  import maze_path_player_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        done_in,
  input  logic        pop_in,
  input  logic [7:0]  loc_in,
  input  logic        stk_empty,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [1:0]  move,
  output logic [7:0]  out_loc,
  output logic        out_last,
  output logic [AW:0] path_len,
  output logic        busy,
  output logic        err
);

  localparam logic [AW:0]   FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE   = 1;
  localparam logic [AW-1:0] ONE_A = 1;

  state_t        state, nxt;
  logic [AW:0]   ptr, rd_idx;
  logic [7:0]    prev, cur;
  logic [AW-1:0] raddr;
  logic          we, full;
  step_t         step;

  // Exactly one nibble may change by one; 4-bit values never wrap.
  function automatic step_t decode_step(input logic [7:0] p, input logic [7:0] c);
    step_t s;
    s.ok = 1'b1;
    s.mv = MV_RIGHT;
    if (p[7:4] == c[7:4] && {1'b0, c[3:0]} == {1'b0, p[3:0]} + 5'd1)      s.mv = MV_RIGHT;
    else if (p[3:0] == c[3:0] && {1'b0, c[7:4]} == {1'b0, p[7:4]} + 5'd1) s.mv = MV_DOWN;
    else if (p[7:4] == c[7:4] && {1'b0, p[3:0]} == {1'b0, c[3:0]} + 5'd1) s.mv = MV_LEFT;
    else if (p[3:0] == c[3:0] && {1'b0, p[7:4]} == {1'b0, c[7:4]} + 5'd1) s.mv = MV_UP;
    else s.ok = 1'b0;
    return s;
  endfunction

  assign full  = (ptr == FULL);
  assign we    = (state == S_COLLECT) && pop_in && !full;
  // LOAD fetches the start entry; PLAY looks one entry below prev.
  assign raddr = (state == S_LOAD) ? path_len[AW-1:0] - ONE_A : rd_idx[AW-1:0] - ONE_A;
  assign step  = decode_step(prev, cur);
  assign busy  = (state != S_IDLE);

  path_lifo_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (ptr[AW-1:0]),
    .wdata (loc_in),
    .raddr (raddr),
    .rdata (cur)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt       = state;
    out_valid = 1'b0;
    move      = MV_RIGHT;
    out_loc   = '0;
    out_last  = 1'b0;
    case (state)
      S_IDLE, S_ERR: if (done_in) nxt = S_COLLECT;
      S_COLLECT: begin
        if (stk_empty && !pop_in)
          nxt = (err || path_len[AW:1] == '0) ? S_ERR : S_LOAD;
      end
      S_LOAD: nxt = S_PLAY;
      S_PLAY: begin
        if (!step.ok) nxt = S_ERR;
        else begin
          out_valid = 1'b1;
          move      = step.mv;
          out_loc   = cur;
          out_last  = (rd_idx == ONE);
          if (out_ready && rd_idx == ONE) nxt = S_IDLE;
        end
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr      <= '0;
      path_len <= '0;
      err      <= 1'b0;
      prev     <= '0;
      rd_idx   <= '0;
    end else begin
      case (state)
        S_IDLE, S_ERR: begin
          if (done_in) begin
            ptr      <= '0;
            path_len <= '0;
            err      <= 1'b0;
          end
        end
        S_COLLECT: begin
          if (pop_in) begin
            if (full) err <= 1'b1;
            else begin
              ptr      <= ptr + ONE;
              path_len <= ptr + ONE;
              if (ptr == '0 && loc_in != LOC_DEST) err <= 1'b1;
            end
          end else if (stk_empty && path_len[AW:1] == '0) begin
            err <= 1'b1;
          end
        end
        S_LOAD: begin
          prev   <= cur;
          rd_idx <= path_len - ONE;
        end
        S_PLAY: begin
          if (!step.ok) err <= 1'b1;
          else if (out_ready) begin
            prev   <= cur;
            rd_idx <= rd_idx - ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
